ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
Write-side client for a dual-port RAM port; converts a byte stream (cartridge/ROM download, or CPU-side fill) into registered RAM write cycles. Also provides a whole-memory zero-fill so RAM starts from a known state, since the RAM itself has no initialisation. Sits between the download/stream source and one port of the RAM; reports progress, byte count, checksum and overflow.

Parameters:
DATA, 8, RAM word width and stream data width
ADDR, 14, RAM address width; memory depth = 2**ADDR words

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
clr_req  in  1  one-cycle pulse: zero-fill entire RAM
ld_base  in  ADDR  load start address, sampled on first accepted beat
ld_valid  in  1  stream beat valid
ld_ready  out  1  stream beat accepted when ld_valid & ld_ready
ld_data  in  DATA  stream data
ld_last  in  1  marks final beat of a load
mem_wr  out  1  RAM write strobe
mem_addr  out  ADDR  RAM address
mem_din  out  DATA  RAM write data
busy  out  1  high in CLEAR or LOAD
done  out  1  one-cycle pulse at end of clear or load
err  out  1  overflow sticky flag; cleared on next clr_req or new load
count  out  ADDR+1  beats written in current/last load
csum  out  16  modulo-2**16 sum of written data (zero-extended)

Behaviour:
- Reset (async assert, sync deassert in the surrounding design): state IDLE; mem_wr, mem_addr, mem_din, busy, done, err, count, csum all 0; any in-flight write dropped.
- States: IDLE, CLEAR, LOAD, DONE. All outputs except ld_ready are registered; ld_ready is decoded from the state and err registers plus clr_req.
- IDLE: ld_ready = !clr_req. clr_req has priority over ld_valid in the same cycle. On clr_req -> CLEAR, with the write pointer at 0 and err = 0. Beat accepted in IDLE -> LOAD, with count = 0, csum = 0, err = 0. The beat is written at ld_base.
- CLEAR: ld_ready = 0. Writes 0 to addresses 0 .. 2**ADDR-1 in order, one per cycle: mem_wr = 1 for exactly 2**ADDR consecutive cycles. After the last write -> DONE. clr_req is ignored while in CLEAR. count and csum are not modified.
- LOAD: ld_ready = !err. Each accepted beat produces on the next cycle mem_wr = 1, mem_addr = (ld_base + count_before) mod 2**ADDR, mem_din = ld_data. The write latency is one cycle. count increments and csum += ld_data in the same cycle as the write.
- LOAD, no beat: mem_wr = 0 on the following cycle. There is no timeout.
- LOAD, ld_last accepted: write issued as usual, then -> DONE. clr_req is ignored in LOAD.
- Address wrap: the address wraps modulo 2**ADDR, independent of count.
- Overflow: if count reaches 2**ADDR without ld_last, err is set and ld_ready drops to 0. Only the first 2**ADDR beats are written.
- Abandoning an overflowed load: the load can be ended only by reset or by a clr_req pulse. clr_req in LOAD with err = 1 -> CLEAR.
- DONE: one cycle; done = 1, mem_wr = 0, ld_ready = 0; then -> IDLE.
- busy: 1 in CLEAR and LOAD, 0 otherwise.
- count, csum and err hold their values in IDLE until the next load or clear starts.
- Reset mid-operation: state, busy and mem_wr are forced to 0 immediately. A partially cleared or partially loaded RAM is left as is.

Test Plan:
- Reset then clr_req pulse, ADDR=4 -> mem_wr high 16 cycles, addresses 0..15, din 0; busy high throughout; done one cycle after the last write; ld_ready 0 during CLEAR.
- ld_base=0x3FFE, beats 0x11,0x22,0x33(last), ADDR=14, valid every cycle -> writes at 0x3FFE,0x3FFF,0x0000 with one-cycle latency; count=3, csum=0x0066; done pulse; err=0.
- Same 3-beat load with ld_valid gapped (valid, idle, idle, valid, valid) -> only three mem_wr cycles, each one cycle after its accepted beat; no spurious writes.
- clr_req and ld_valid asserted in the same IDLE cycle -> ld_ready=0, CLEAR entered, beat not consumed.
- ADDR=4, 17 beats without last -> 16 writes; err=1 after the 16th; ld_ready=0. Then clr_req -> CLEAR, err=0.
- reset_n asserted during CLEAR at address 5 -> mem_wr=0, busy=0 immediately; after release, state is IDLE and ld_ready=1.

Source files
------------

// File: rtl/ram_loader.sv
// Write-side client for one RAM port: turns a byte stream into registered RAM
// writes and provides a whole-memory zero-fill, with progress and checksum.
module ram_loader #(
  parameter int unsigned DATA = 8,
  parameter int unsigned ADDR = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_req,
  input  logic [ADDR-1:0] ld_base,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [DATA-1:0] ld_data,
  input  logic            ld_last,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR:0]   count,
  output logic [15:0]     csum
);

  localparam int unsigned CW = ADDR + 1;
  localparam int unsigned SW = 16;
  localparam logic [ADDR-1:0] ADDR_MAX = {ADDR{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = {1'b0, {ADDR{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            fin_q, fin_d;
  logic [ADDR-1:0] base_q, base_d;
  logic            mem_wr_d;
  logic [ADDR-1:0] mem_addr_d;
  logic [DATA-1:0] mem_din_d;
  logic            busy_d;
  logic            done_d;
  logic            err_d;
  logic [CW-1:0]   count_d;
  logic [SW-1:0]   csum_d;
  logic            accept;

  // fin_q marks the cycle in which the final beat's write is on the bus.
  assign ld_ready = ((state_q == S_IDLE) && !clr_req) ||
                    ((state_q == S_LOAD) && !err && !fin_q);
  assign accept   = ld_valid && ld_ready;

  always_comb begin
    state_d    = state_q;
    fin_d      = fin_q;
    base_d     = base_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    done_d     = 1'b0;
    err_d      = err;
    count_d    = count;
    csum_d     = csum;

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d    = S_CLEAR;
          mem_wr_d   = 1'b1;
          mem_addr_d = '0;
          mem_din_d  = '0;
          err_d      = 1'b0;
        end else if (accept) begin
          state_d    = S_LOAD;
          base_d     = ld_base;
          mem_wr_d   = 1'b1;
          mem_addr_d = ld_base;
          mem_din_d  = ld_data;
          count_d    = CW'(1);
          csum_d     = SW'(ld_data);
          err_d      = 1'b0;
          fin_d      = ld_last;
        end
      end
      // mem_addr doubles as the fill pointer
      S_CLEAR: begin
        if (mem_addr == ADDR_MAX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          mem_wr_d   = 1'b1;
          mem_addr_d = mem_addr + ADDR'(1);
          mem_din_d  = '0;
        end
      end
      S_LOAD: begin
        if (fin_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          fin_d   = 1'b0;
        end else if (err && clr_req) begin
          state_d    = S_CLEAR;
          mem_wr_d   = 1'b1;
          mem_addr_d = '0;
          mem_din_d  = '0;
          err_d      = 1'b0;
        end else if (accept) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = base_q + count[ADDR-1:0];
          mem_din_d  = ld_data;
          count_d    = count + CW'(1);
          csum_d     = csum + SW'(ld_data);
          if (ld_last) begin
            fin_d = 1'b1;
          end else if (count == CNT_LAST) begin
            err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CLEAR) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      fin_q    <= 1'b0;
      base_q   <= '0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      csum     <= '0;
    end else begin
      state_q  <= state_d;
      fin_q    <= fin_d;
      base_q   <= base_d;
      mem_wr   <= mem_wr_d;
      mem_addr <= mem_addr_d;
      mem_din  <= mem_din_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      count    <= count_d;
      csum     <= csum_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader at ADDR=4: table-driven loads, zero-fill, collision,
// overflow and mid-clear reset sequences, plus random loads against a model.
module tb_ram_loader;

  localparam int unsigned DATA = 8;
  localparam int unsigned ADDR = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clr_req;
  logic [ADDR-1:0] ld_base;
  logic            ld_valid;
  logic            ld_ready;
  logic [DATA-1:0] ld_data;
  logic            ld_last;
  logic            mem_wr;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_din;
  logic            busy;
  logic            done;
  logic            err;
  logic [ADDR:0]   count;
  logic [15:0]     csum;

  always #5 clk = ~clk;

  ram_loader #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .done(done), .err(err),
    .count(count), .csum(csum)
  );

  typedef struct {
    logic [3:0]  base;
    logic [7:0]  d0, d1, d2;
    int          g1, g2;
    logic [3:0]  a0, a1, a2;
    logic [15:0] sum;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  bd [16];
  int          bg [16];
  logic [3:0]  ba [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic [3:0] b, input logic c);
    @(posedge clk);
    #1;
    ld_valid = v; ld_data = d; ld_last = l; ld_base = b; clr_req = c;
    @(negedge clk);
  endtask

  task automatic chk_wr(input string nm, input logic pend, input logic [3:0] pa,
                        input logic [7:0] pd);
    check({nm, "_wr"}, 32'(mem_wr), 32'(pend));
    if (pend) begin
      check({nm, "_addr"}, 32'(mem_addr), 32'(pa));
      check({nm, "_din"}, 32'(mem_din), 32'(pd));
    end
  endtask

  // Beats bd[0..n-1], gap bg[i] idle cycles before beat i, expected addresses ba[].
  task automatic run_load(input logic [3:0] base, input int n, input logic [15:0] esum,
                          input bit rclr);
    logic pend;
    logic [3:0] pa;
    logic [7:0] pd;
    pend = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < bg[i]; g++) begin
        drive(1'b0, 8'($urandom), 1'b0, 4'($urandom),
              (i > 0) && rclr && ($urandom_range(0, 1) == 1));
        chk_wr("load_gap", pend, pa, pd);
        pend = 1'b0;
      end
      drive(1'b1, bd[i], i == n - 1, (i == 0) ? base : 4'($urandom),
            (i > 0) && rclr && ($urandom_range(0, 1) == 1));
      chk_wr("load_beat", pend, pa, pd);
      check("load_ready", 32'(ld_ready), 32'd1);
      pend = 1'b1; pa = ba[i]; pd = bd[i];
    end
    drive(1'b1, 8'hA5, 1'b0, 4'($urandom), 1'b0);
    chk_wr("load_tail", pend, pa, pd);
    check("load_tail_ready", 32'(ld_ready), 32'd0);
    check("load_tail_busy", 32'(busy), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("load_done", 32'(done), 32'd1);
    check("load_done_wr", 32'(mem_wr), 32'd0);
    check("load_done_busy", 32'(busy), 32'd0);
    check("load_count", 32'(count), 32'(n));
    check("load_csum", 32'(csum), 32'(esum));
    check("load_err", 32'(err), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("load_idle_done", 32'(done), 32'd0);
    check("load_idle_ready", 32'(ld_ready), 32'd1);
  endtask

  // Called once clr_req has been presented in the previous cycle.
  task automatic clear_body(input logic [4:0] ec, input logic [15:0] es);
    for (int i = 0; i < 16; i++) begin
      drive(i[0], 8'($urandom), 1'b0, 4'($urandom), i == 3);
      check("clr_wr", 32'(mem_wr), 32'd1);
      check("clr_addr", 32'(mem_addr), 32'(i));
      check("clr_din", 32'(mem_din), 32'd0);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ready", 32'(ld_ready), 32'd0);
      check("clr_err", 32'(err), 32'd0);
      check("clr_count", 32'(count), 32'(ec));
      check("clr_csum", 32'(csum), 32'(es));
    end
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("clr_done", 32'(done), 32'd1);
    check("clr_done_wr", 32'(mem_wr), 32'd0);
    check("clr_done_busy", 32'(busy), 32'd0);
    check("clr_done_ready", 32'(ld_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("clr_idle_done", 32'(done), 32'd0);
    check("clr_idle_ready", 32'(ld_ready), 32'd1);
  endtask

  task automatic run_clear(input logic v, input logic [4:0] ec, input logic [15:0] es);
    drive(v, 8'h99, 1'b1, 4'h3, 1'b1);
    check("clr_req_ready", 32'(ld_ready), 32'd0);
    check("clr_req_wr", 32'(mem_wr), 32'd0);
    clear_body(ec, es);
  endtask

  initial begin
    vec_t        tbl [5];
    logic [3:0]  base;
    logic [15:0] s;
    logic [4:0]  lc;
    logic [15:0] ls;
    int          n;

    tbl[0] = '{4'hE, 8'h11, 8'h22, 8'h33, 0, 0, 4'hE, 4'hF, 4'h0, 16'h0066};
    tbl[1] = '{4'hE, 8'h11, 8'h22, 8'h33, 2, 0, 4'hE, 4'hF, 4'h0, 16'h0066};
    tbl[2] = '{4'h0, 8'hFF, 8'hFF, 8'hFF, 0, 1, 4'h0, 4'h1, 4'h2, 16'h02FD};
    tbl[3] = '{4'h7, 8'h80, 8'h01, 8'h7F, 1, 1, 4'h7, 4'h8, 4'h9, 16'h0100};
    tbl[4] = '{4'hF, 8'h00, 8'hAA, 8'h55, 0, 3, 4'hF, 4'h0, 4'h1, 16'h00FF};

    reset_n = 1'b0; clr_req = 1'b0; ld_base = '0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_csum", 32'(csum), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd1);

    run_clear(1'b0, 5'd0, 16'd0);
    // clr_req and a beat together: clear wins, beat is not consumed
    run_clear(1'b1, 5'd0, 16'd0);

    for (int e = 0; e < 5; e++) begin
      bd[0] = tbl[e].d0; bd[1] = tbl[e].d1; bd[2] = tbl[e].d2;
      bg[0] = 0; bg[1] = tbl[e].g1; bg[2] = tbl[e].g2;
      ba[0] = tbl[e].a0; ba[1] = tbl[e].a1; ba[2] = tbl[e].a2;
      run_load(tbl[e].base, 3, tbl[e].sum, 1'b0);
    end

    // full-depth load ending exactly at 2**ADDR beats: no overflow
    base = 4'h9; s = '0;
    for (int i = 0; i < 16; i++) begin
      bd[i] = 8'(i * 17 + 3); bg[i] = 0; ba[i] = 4'(base + 4'(i));
      s = s + 16'(bd[i]);
    end
    run_load(base, 16, s, 1'b0);

    lc = '0; ls = '0;
    for (int t = 0; t < 30; t++) begin
      base = 4'($urandom); n = $urandom_range(1, 16); s = '0;
      for (int i = 0; i < n; i++) begin
        bd[i] = 8'($urandom); bg[i] = $urandom_range(0, 2);
        ba[i] = 4'(base + 4'(i)); s = s + 16'(bd[i]);
      end
      run_load(base, n, s, 1'b1);
      lc = 5'(n); ls = s;
    end
    run_clear(1'b0, lc, ls);

    // overflow: 17 beats offered without last
    base = 4'h5; s = '0;
    for (int i = 0; i < 16; i++) begin
      bd[i] = 8'($urandom);
      drive(1'b1, bd[i], 1'b0, (i == 0) ? base : 4'($urandom), 1'b0);
      if (i == 0) chk_wr("ovf", 1'b0, 4'h0, 8'h00);
      else        chk_wr("ovf", 1'b1, 4'(base + 4'(i - 1)), bd[i - 1]);
      check("ovf_ready", 32'(ld_ready), 32'd1);
      s = s + 16'(bd[i]);
    end
    drive(1'b1, 8'hEE, 1'b0, 4'($urandom), 1'b0);
    chk_wr("ovf_16th", 1'b1, 4'(base + 4'd15), bd[15]);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_ready_low", 32'(ld_ready), 32'd0);
    check("ovf_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'hEE, 1'b0, 4'($urandom), 1'b0);
      check("ovf_hold_wr", 32'(mem_wr), 32'd0);
      check("ovf_hold_ready", 32'(ld_ready), 32'd0);
      check("ovf_hold_err", 32'(err), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    check("ovf_clr_ready", 32'(ld_ready), 32'd0);
    check("ovf_clr_wr", 32'(mem_wr), 32'd0);
    clear_body(5'd16, s);

    // reset in the middle of a clear, right after address 5 is written
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
      check("mid_addr", 32'(mem_addr), 32'(i));
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr", 32'(mem_wr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
      check("post_rst_ready", 32'(ld_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_wr", 32'(mem_wr), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
